// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
//
// Round-robin scan controller for a 4:1 mux. On start it walks the mux
// select through channels 0..3, waits SETTLE cycles on each channel, and
// samples the mux output y. When all four channels are sampled it presents
// them together on q with a one-cycle valid strobe.
//
// Parameters
//   SETTLE  wait cycles per channel before sampling y (0..255)
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   scan request, accepted only while idle
//   y       in   mux output for the currently selected channel
//   s       out  [0:1] mux select, s[0] is the MSB of the channel index
//   q       out  [0:3] scan result, q[k] = y sampled on channel k
//   valid   out  one-cycle strobe, q has just been updated
//   busy    out  high while a scan is in progress
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, busy low
// SCAN  | stepping channels, counting settle cycles, sampling y
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic [0:1] s,
    output logic [0:3] q,
    output logic       valid,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [0:3] sh;
    logic [0:3] sh_nxt;
    logic [0:1] s_nxt;
    logic [0:3] q_nxt;
    logic       valid_nxt;
    logic       busy_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            sh    <= 4'b0000;
            s     <= 2'b00;
            q     <= 4'b0000;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sh    <= sh_nxt;
            s     <= s_nxt;
            q     <= q_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sh_nxt    = sh;
        s_nxt     = s;
        q_nxt     = q;
        valid_nxt = 1'b0;
        busy_nxt  = busy;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                    s_nxt     = 2'b00;
                    cnt_nxt   = 8'd0;
                    busy_nxt  = 1'b1;
                end
            end

            SCAN: begin
                if (cnt != SETTLE_CNT) begin
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    sh_nxt[s] = y;
                    cnt_nxt   = 8'd0;
                    if (s != 2'b11) begin
                        s_nxt = s + 2'd1;
                    end else begin
                        // Last channel goes straight from y so all four bits
                        // land in q on the same edge.
                        q_nxt     = {sh[0], sh[1], sh[2], y};
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                        s_nxt     = 2'b00;
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                s_nxt     = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;

    // DUT 0: SETTLE = 1
    logic       start0;
    logic [0:3] a0;
    logic       y0;
    logic [0:1] s0;
    logic [0:3] q0;
    logic       valid0;
    logic       busy0;

    // DUT 1: SETTLE = 0
    logic       start1;
    logic [0:3] a1;
    logic       y1;
    logic [0:1] s1;
    logic [0:3] q1;
    logic       valid1;
    logic       busy1;

    logic [0:3] exp_q[$];
    int         n_checks;
    int         n_pass;

    // behavioural 4:1 mux: y = a[s]
    assign y0 = a0[s0];
    assign y1 = a1[s1];

    mux_scan_ctrl #(.SETTLE(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start0),
        .y     (y0),
        .s     (s0),
        .q     (q0),
        .valid (valid0),
        .busy  (busy0)
    );

    mux_scan_ctrl #(.SETTLE(0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .y     (y1),
        .s     (s1),
        .q     (q1),
        .valid (valid1),
        .busy  (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start0 = 1'b1;
        start1 = 1'b1;
        a0     = 4'b1111;
        a1     = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({s0, q0, valid0, busy0} !== 8'b0) begin
                $display("FAIL reset_dut0 cycle %0d: s=%b q=%b valid=%b busy=%b, required all zero",
                         i, s0, q0, valid0, busy0);
            end else n_pass++;
            n_checks++;
            if ({s1, q1, valid1, busy1} !== 8'b0) begin
                $display("FAIL reset_dut1 cycle %0d: s=%b q=%b valid=%b busy=%b, required all zero",
                         i, s1, q1, valid1, busy1);
            end else n_pass++;
        end
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n  = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_basic_scan();
        logic [1:0] es;
        logic [0:3] e;
        a0     = 4'b0101;
        start0 = 1'b1;
        exp_q.push_back(4'b0101);
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            es = 2'(i / 2);
            n_checks++;
            if (s0 !== es || busy0 !== 1'b1 || valid0 !== 1'b0) begin
                $display("FAIL basic_scan cycle %0d: s=%b busy=%b valid=%b, required s=%b busy=1 valid=0",
                         i + 1, s0, busy0, valid0, es);
            end else n_pass++;
            tick();
        end
        e = exp_q.pop_front();
        n_checks++;
        if (valid0 !== 1'b1 || busy0 !== 1'b0 || q0 !== e) begin
            $display("FAIL basic_done: valid=%b busy=%b q=%b, required valid=1 busy=0 q=%b",
                     valid0, busy0, q0, e);
        end else n_pass++;
        tick();
        n_checks++;
        if (valid0 !== 1'b0 || q0 !== e) begin
            $display("FAIL basic_after: valid=%b q=%b, required valid=0 q=%b", valid0, q0, e);
        end else n_pass++;
    endtask

    task automatic test_data_change();
        logic [0:3] e;
        bit         seen;
        a0     = 4'b1100;
        start0 = 1'b1;
        exp_q.push_back(4'b1100);
        tick();
        start0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (valid0 === 1'b1) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                n_checks++;
                if (q0 !== e) begin
                    $display("FAIL data_change_q: q=%b, required %b", q0, e);
                end else n_pass++;
            end else begin
                n_checks++;
                if (q0 !== 4'b0101) begin
                    $display("FAIL data_change_hold cycle %0d: q=%b, required 0101", i, q0);
                end else n_pass++;
                tick();
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL data_change_timeout: valid=%b, required 1 within 20 cycles", valid0);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int         n_busy;
        int         n_valid;
        logic [0:3] e;
        a0     = 4'b0011;
        start0 = 1'b1;
        exp_q.push_back(4'b0011);
        tick();
        start0 = 1'b0;
        n_busy  = 0;
        n_valid = 0;
        for (int i = 1; i <= 25; i++) begin
            if (busy0 === 1'b1) n_busy++;
            if (valid0 === 1'b1) begin
                n_valid++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (q0 !== e) begin
                        $display("FAIL ignored_start_q: q=%b, required %b", q0, e);
                    end else n_pass++;
                end
            end
            start0 = (i == 3) ? 1'b1 : 1'b0;
            tick();
        end
        start0 = 1'b0;
        n_checks++;
        if (n_busy != 8) begin
            $display("FAIL ignored_start_len: busy cycles=%0d, required 8", n_busy);
        end else n_pass++;
        n_checks++;
        if (n_valid != 1) begin
            $display("FAIL ignored_start_valid: valid count=%0d, required 1", n_valid);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] es;
        logic [0:3] e;
        a1     = 4'b1001;
        start1 = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(4'b1001);
        tick();
        for (int j = 1; j <= 15; j++) begin
            if (j % 5 == 0) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
                n_checks++;
                if (valid1 !== 1'b1 || busy1 !== 1'b0 || s1 !== 2'b00 || q1 !== e) begin
                    $display("FAIL b2b_valid cycle %0d: valid=%b busy=%b s=%b q=%b, required valid=1 busy=0 s=00 q=%b",
                             j, valid1, busy1, s1, q1, e);
                end else n_pass++;
            end else begin
                es = 2'((j % 5) - 1);
                n_checks++;
                if (s1 !== es || busy1 !== 1'b1 || valid1 !== 1'b0) begin
                    $display("FAIL b2b_scan cycle %0d: s=%b busy=%b valid=%b, required s=%b busy=1 valid=0",
                             j, s1, busy1, valid1, es);
                end else n_pass++;
            end
            if (j == 15) start1 = 1'b0;
            tick();
        end
        n_checks++;
        if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
            $display("FAIL b2b_stop: busy=%b valid=%b, required busy=0 valid=0", busy1, valid1);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        bit         seen;
        int         n_valid;
        int         len;
        logic [0:3] e;
        a0     = 4'b0110;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (s0 === 2'b10) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL mid_reset_reach: s=%b, required 10 within 10 cycles", s0);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (s0 !== 2'b00 || q0 !== 4'b0000 || busy0 !== 1'b0 || valid0 !== 1'b0) begin
            $display("FAIL mid_reset_clear: s=%b q=%b busy=%b valid=%b, required all zero",
                     s0, q0, busy0, valid0);
        end else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid0 === 1'b1 || busy0 === 1'b1) n_valid++;
        end
        n_checks++;
        if (n_valid != 0) begin
            $display("FAIL mid_reset_quiet: valid/busy cycles=%0d, required 0", n_valid);
        end else n_pass++;

        a0     = 4'b1010;
        start0 = 1'b1;
        exp_q.push_back(4'b1010);
        tick();
        start0 = 1'b0;
        seen = 1'b0;
        len  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            len++;
            if (valid0 === 1'b1) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL post_reset_timeout: valid=%b, required 1 within 20 cycles", valid0);
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (q0 !== e || len != 9) begin
                $display("FAIL post_reset_scan: q=%b valid at cycle %0d, required q=%b at cycle 8",
                         q0, len - 1, e);
            end else n_pass++;
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        a0       = 4'b0000;
        a1       = 4'b0000;
        #2;
        test_reset();
        test_basic_scan();
        test_data_change();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_scan();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
        end else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
